// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//
// Bundles the signals around the instruction fetch unit:
//   - the instruction-memory request/acknowledge channel
//   - the decoded-instruction channel toward the control unit / datapath
//   - the redirect (taken branch / jump) input
//
// Modports:
//   master : the fetch unit itself (drives imem request and decoded fields)
//   slave  : the surroundings (memory, control unit, branch resolution)
//
// Parameter:
//   ADDR_W : width of program counter and instruction-memory address
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 32
) ();

    // Instruction memory channel
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    // Decoded instruction channel
    logic              dec_valid;
    logic              dec_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc_out;
    logic              illegal;

    // Control-flow redirect
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output dec_valid,
        input  dec_ready,
        output opcode,
        output funct3,
        output funct7,
        output rd,
        output rs1,
        output rs2,
        output instr,
        output pc_out,
        output illegal,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  dec_valid,
        output dec_ready,
        input  opcode,
        input  funct3,
        input  funct7,
        input  rd,
        input  rs1,
        input  rs2,
        input  instr,
        input  pc_out,
        input  illegal,
        output redirect,
        output redirect_pc
    );

endinterface : instr_fetch_if

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-outstanding-request instruction fetch unit. Fetches one 32-bit word
// at a time from instruction memory, holds it and presents its decoded fields
// to the control unit until accepted, then advances the PC by 4. A redirect
// replaces the PC; any word that is in flight or being held at that moment is
// discarded.
//
// Parameters:
//   ADDR_W   : width of PC / memory address
//   RESET_PC : first fetch address after reset
//
// Ports:
//   clk : single clock, all state on the rising edge
//   rst : synchronous, active-high reset
//   bus : instr_fetch_if.master
//         imem_req/imem_addr/imem_ack/imem_rdata   memory request channel
//         dec_valid/dec_ready                      decode handshake
//         opcode/funct3/funct7/rd/rs1/rs2/instr    slices of the held word
//         pc_out                                   address of the held word
//         illegal                                  held word is not a 32-bit
//                                                  encoding (instr[1:0]!=11)
//         redirect/redirect_pc                     taken branch / jump
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);

    // FETCH : request outstanding at pc_r
    // ISSUE : word held, presented to the control unit
    // FLUSH : request outstanding at flush_addr_r, its data will be dropped
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_ISSUE = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [31:0]       NOP_INSTR = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(32'd3);

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~WORD_MASK;
    endfunction

    // A 32-bit encoding always carries 2'b11 in its two lowest bits.
    function automatic logic is_illegal(input logic [31:0] word);
        return (word[1:0] != 2'b11);
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] pc_r;          // next address to fetch / address of held word
    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] flush_addr_r;  // address of the abandoned request
    logic [ADDR_W-1:0] flush_addr_s;
    logic [31:0]       instr_r;
    logic [31:0]       instr_s;
    logic [ADDR_W-1:0] pc_out_r;
    logic [ADDR_W-1:0] pc_out_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            flush_addr_r <= RESET_PC;
            instr_r      <= NOP_INSTR;
            pc_out_r     <= RESET_PC;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            flush_addr_r <= flush_addr_s;
            instr_r      <= instr_s;
            pc_out_r     <= pc_out_s;
        end
    end

    // Next-state and next-datapath logic; redirect outranks ack / dec_ready.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        flush_addr_s = flush_addr_r;
        instr_s      = instr_r;
        pc_out_s     = pc_out_r;

        case (state_r)
            ST_FETCH: begin
                if (bus.redirect) begin
                    pc_s = word_align(bus.redirect_pc);
                    if (bus.imem_ack) begin
                        // Response arrives together with redirect: drop it
                        // and start the new fetch straight away.
                        state_s = ST_FETCH;
                    end else begin
                        // The request must stay on the bus at its old address
                        // until memory answers it.
                        flush_addr_s = pc_r;
                        state_s      = ST_FLUSH;
                    end
                end else if (bus.imem_ack) begin
                    instr_s  = bus.imem_rdata;
                    pc_out_s = pc_r;
                    state_s  = ST_ISSUE;
                end else begin
                    state_s = ST_FETCH;
                end
            end

            ST_ISSUE: begin
                if (bus.redirect) begin
                    // Held word is discarded even if accepted this cycle.
                    pc_s    = word_align(bus.redirect_pc);
                    state_s = ST_FETCH;
                end else if (bus.dec_ready) begin
                    pc_s    = pc_r + PC_STEP;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_ISSUE;
                end
            end

            ST_FLUSH: begin
                if (bus.redirect) begin
                    pc_s = word_align(bus.redirect_pc);
                end else begin
                    pc_s = pc_r;
                end
                if (bus.imem_ack) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_FLUSH;
                end
            end

            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // The request is masked during reset so it drops in the reset cycle and
    // is already up in the first cycle after reset releases.
    assign bus.imem_req  = ((state_r == ST_FETCH) || (state_r == ST_FLUSH)) && !rst;
    assign bus.imem_addr = (state_r == ST_FLUSH) ? flush_addr_r : pc_r;

    assign bus.dec_valid = (state_r == ST_ISSUE);

    // Decoded fields are slices of the held register only; imem_rdata never
    // reaches these outputs combinationally.
    assign bus.instr   = instr_r;
    assign bus.opcode  = instr_r[6:0];
    assign bus.rd      = instr_r[11:7];
    assign bus.funct3  = instr_r[14:12];
    assign bus.rs1     = instr_r[19:15];
    assign bus.rs2     = instr_r[24:20];
    assign bus.funct7  = instr_r[31:25];
    assign bus.pc_out  = pc_out_r;
    assign bus.illegal = is_illegal(instr_r);

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// The bench plays instruction memory, control unit and branch unit. A
// transaction-level model predicts the address of every new memory request
// and which fetched words reach the control unit; those words go into a
// scoreboard queue, and a separate monitor pops one each time dec_valid rises
// and compares the presented instruction against it.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(32)) bus  ();
    instr_fetch_if #(.ADDR_W(32)) bus2 ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Second instance starting just below the top of the address space.
    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Wrap instance: memory answers immediately, control unit always ready.
    assign bus2.imem_ack    = bus2.imem_req;
    assign bus2.imem_rdata  = 32'h0000_0013;
    assign bus2.dec_ready   = 1'b1;
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } item_t;

    item_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [31:0] m_next;       // address the next new request must carry
    logic [31:0] out_addr;     // address of the request currently outstanding
    logic [31:0] held_pc;      // address of the word the control unit sees
    bit          outstanding;
    bit          out_dirty;    // a redirect hit the outstanding request
    bit          exp_valid;
    bit          exp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        bus.dec_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0000_0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        sb_q.delete();
        m_next      = 32'h0000_0000;
        outstanding = 1'b0;
        out_dirty   = 1'b0;
        exp_valid   = 1'b0;
        exp_req     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_req",       32'(bus.imem_req),  32'h0);
        chk("reset_valid",     32'(bus.dec_valid), 32'h0);
        chk("reset_pc_out",    bus.pc_out,         32'h0000_0000);
        chk("reset_instr",     bus.instr,          32'h0000_0013);
        chk("wrap_reset_pc",   bus2.pc_out,        32'hFFFF_FFFC);
        rst     = 1'b0;
        exp_req = 1'b1;
    endtask

    // One clock cycle: observe the DUT at the falling edge, update the model
    // with the inputs about to be applied, then apply them.
    task automatic drive(input bit ack, input logic [31:0] rdata, input bit rdy,
                         input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        if (exp_req) chk("req_after_accept", 32'(bus.imem_req), 32'h1);
        exp_req = 1'b0;
        if (exp_valid) chk("valid_latency", 32'(bus.dec_valid), 32'h1);
        exp_valid = 1'b0;

        if (bus.imem_req) begin
            if (!outstanding) begin
                chk("req_addr", bus.imem_addr, m_next);
                outstanding = 1'b1;
                out_addr    = m_next;
                out_dirty   = 1'b0;
            end else begin
                chk("req_stable", bus.imem_addr, out_addr);
            end
        end

        if (redir && outstanding) out_dirty = 1'b1;

        if (ack && bus.imem_req) begin
            outstanding = 1'b0;
            if (!out_dirty) begin
                sb_q.push_back('{out_addr, rdata});
                held_pc   = out_addr;
                exp_valid = 1'b1;
            end
        end

        if (bus.dec_valid && (rdy || redir)) exp_req = 1'b1;

        if (redir) begin
            m_next = {rpc[31:2], 2'b00};
        end else if (bus.dec_valid && rdy) begin
            m_next = held_pc + 32'd4;
        end

        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.dec_ready   = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
    endtask

    // Monitor: pops the scoreboard whenever a new instruction is presented and
    // checks that a presented instruction stays still while it is held.
    initial begin
        item_t       it;
        logic [31:0] held_w;
        logic [31:0] held_p;
        bit          prev_valid;
        prev_valid = 1'b0;
        held_w     = 32'h0;
        held_p     = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.dec_valid) begin
                    chk("req_while_valid", 32'(bus.imem_req), 32'h0);
                end
                if (bus.dec_valid && !prev_valid) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_valid: got pc_out %08h instr %08h, expected no instruction",
                                 bus.pc_out, bus.instr);
                    end else begin
                        it = sb_q.pop_front();
                        chk("instr",   bus.instr,          it.word);
                        chk("pc_out",  bus.pc_out,         it.pc);
                        chk("opcode",  32'(bus.opcode),    32'(it.word[6:0]));
                        chk("rd",      32'(bus.rd),        32'(it.word[11:7]));
                        chk("funct3",  32'(bus.funct3),    32'(it.word[14:12]));
                        chk("rs1",     32'(bus.rs1),       32'(it.word[19:15]));
                        chk("rs2",     32'(bus.rs2),       32'(it.word[24:20]));
                        chk("funct7",  32'(bus.funct7),    32'(it.word[31:25]));
                        chk("illegal", 32'(bus.illegal),   32'(it.word[1:0] != 2'b11));
                    end
                    held_w = bus.instr;
                    held_p = bus.pc_out;
                end else if (bus.dec_valid) begin
                    chk("hold_instr", bus.instr,  held_w);
                    chk("hold_pc",    bus.pc_out, held_p);
                end
                prev_valid = bus.dec_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        bit          r_ack;
        bit          r_rdy;
        bit          r_redir;
        logic [31:0] r_data;
        logic [31:0] r_pc;

        idle_inputs();
        do_reset();
        #1;
        chk("wrap_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);

        // Basic fetch: ack one cycle after the request, ADD x3,x5,x6
        drive(1'b1, 32'h0062_81B3, 1'b1, 1'b0, 32'h0);
        chk("wrap_valid",      32'(bus2.dec_valid), 32'h1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("add_valid",   32'(bus.dec_valid), 32'h1);
        chk("add_opcode",  32'(bus.opcode),    32'h33);
        chk("add_funct3",  32'(bus.funct3),    32'h0);
        chk("add_funct7",  32'(bus.funct7),    32'h0);
        chk("add_rd",      32'(bus.rd),        32'h3);
        chk("add_rs1",     32'(bus.rs1),       32'h5);
        chk("add_rs2",     32'(bus.rs2),       32'h6);
        chk("wrap_next_addr", bus2.imem_addr,  32'h0000_0000);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("next_addr_4", bus.imem_addr, 32'h0000_0004);

        // Control unit stalls for five cycles
        drive(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'h0);
        repeat (5) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("stall_pc_out", bus.pc_out, 32'h0000_0004);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Redirect while issuing, together with dec_ready
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("issue_redir_valid", 32'(bus.dec_valid), 32'h0);
        chk("issue_redir_addr",  bus.imem_addr,      32'h0000_0100);

        // Redirect while fetching, ack three cycles later
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0040);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("flush_addr_held", bus.imem_addr, 32'h0000_0100);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        chk("flush_no_valid", 32'(bus.dec_valid), 32'h0);

        // Illegal / legal encodings
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
        chk("fetch_redir_addr", bus.imem_addr, 32'h0000_0040);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("illegal_zero", 32'(bus.illegal), 32'h1);
        drive(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("illegal_nop", 32'(bus.illegal), 32'h0);

        // Random traffic with one mid-stream reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            r_ack   = ($urandom_range(0, 2) == 0);
            r_data  = $urandom;
            r_rdy   = ($urandom_range(0, 1) == 1);
            r_redir = ($urandom_range(0, 11) == 0);
            r_pc    = $urandom;
            drive(r_ack, r_data, r_rdy, r_redir, r_pc);
        end

        repeat (4) drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32, width of PC and memory address.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 imem_req  out  1  instruction memory request.
REQ-006 imem_addr  out  ADDR_W  word-aligned fetch address.
REQ-007 imem_ack  in  1  memory completes request this cycle; imem_rdata valid.
REQ-008 imem_rdata  in  32  fetched instruction word.
REQ-009 dec_valid  out  1  decoded fields valid toward control unit.
REQ-010 dec_ready  in  1  control unit/datapath accepts current instruction.
REQ-011 opcode  out  7  instr[6:0].
REQ-012 funct3  out  3  instr[14:12].
REQ-013 funct7  out  7  instr[31:25].
REQ-014 rd / rs1 / rs2  out  5 each  instr[11:7] / [19:15] / [24:20].
REQ-015 instr  out  32  full held word (for immediate generator).
REQ-016 pc_out  out  ADDR_W  address of held instruction.
REQ-017 illegal  out  1  held word has instr[1:0] != 2'b11; valid only with dec_valid.
REQ-018 redirect  in  1  branch/jump taken; one-cycle pulse.
REQ-019 redirect_pc  in  ADDR_W  target address for redirect.

Function
REQ-020 States: FETCH, ISSUE, FLUSH; encoding free.
REQ-021 FETCH: imem_req=1, imem_addr=pc; on imem_ack latch imem_rdata into instr register, pc_out<=pc, go ISSUE.
REQ-022 imem_req and imem_addr SHALL stay stable from assertion until the cycle imem_ack is seen.
REQ-023 ISSUE: imem_req=0, dec_valid=1, all field outputs constant; on dec_ready, pc<=pc+4, go FETCH.
REQ-024 Fetch-to-valid latency: dec_valid rises the cycle after imem_ack; ack-to-next-req minimum 2 cycles (one ISSUE cycle when dec_ready held high).
REQ-025 PC arithmetic modulo 2^ADDR_W; pc+4 from all-ones-minus-3 wraps to 0 without flag.
REQ-026 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-027 redirect in ISSUE: pc<=redirect_pc, dec_valid drops next cycle, held word discarded even if dec_ready same cycle, go FETCH.
REQ-028 redirect in FETCH with imem_ack same cycle: rdata discarded, pc<=redirect_pc, stay FETCH.
REQ-029 redirect in FETCH without imem_ack: pc<=redirect_pc, go FLUSH; outstanding request held at old address.
REQ-030 FLUSH: imem_req=1 at old address; on imem_ack discard data, go FETCH; dec_valid=0.
REQ-031 redirect in FLUSH: pc<=redirect_pc (latest wins), stay FLUSH until ack.
REQ-032 Priority: rst > redirect > imem_ack/dec_ready.
REQ-033 Field outputs are pure slices of the instr register; no combinational path from imem_rdata to outputs.
REQ-034 dec_valid SHALL never assert in FETCH or FLUSH.

Reset
REQ-035 On rst: state FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), pc_out=RESET_PC, dec_valid=0.
REQ-036 imem_req SHALL be 0 during the reset cycle and 1 the first cycle after rst deasserts.
REQ-037 rst mid-transaction abandons outstanding request; a late imem_ack after reset is treated as response to the new RESET_PC request.

Verification
REQ-038 Reset, ack after 1 cycle with rdata=32'h0062_81B3, dec_ready=1 -> imem_addr=0, dec_valid with opcode=7'h33, funct3=0, funct7=0, rd=3, rs1=5, rs2=6; next req addr=4.
REQ-039 dec_ready low 5 cycles in ISSUE -> dec_valid and all fields stable 5 cycles, no imem_req, pc unchanged.
REQ-040 Redirect to 32'h0000_0102 in ISSUE -> dec_valid drops, next imem_addr=32'h0000_0100.
REQ-041 Redirect to 32'h40 in FETCH, ack 3 cycles later -> addr stays old until ack, data discarded, next imem_addr=32'h40, no dec_valid in between.
REQ-042 RESET_PC=32'hFFFF_FFFC, accept one instruction -> next imem_addr=0.
REQ-043 rdata=32'h0000_0000 -> dec_valid with illegal=1; rdata=32'h0000_0013 -> illegal=0.
